// File: rtl/mnist_pkg.sv
// Shared widths and types for the MNIST neuron datapath.
package mnist_pkg;

    localparam int PIXEL_W   = 8;
    localparam int WEIGHT_W  = 8;
    localparam int PROD_W    = 17;
    localparam int N_PIXELS  = 784;
    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;
    localparam int BIAS_W    = 16;
    localparam int CNT_W     = 10;

    typedef struct packed {
        logic clr;
        logic vld;
        logic done;
    } strobe_t;

endpackage

// File: rtl/strobe_delay.sv
// DEPTH-stage shift register that lines controller strobes up with memory read data.
module strobe_delay #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mac_unit.sv
// Neuron MAC: align strobes to memory latency, multiply, accumulate, then
// bias/shift/ReLU/saturate into one activation per done strobe.
module mac_unit
    import mnist_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT   = 0,
    parameter int RELU    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_acc,
    input  logic                       valid_mac,
    input  logic                       done,
    input  logic        [PIXEL_W-1:0]  pixel,
    input  logic signed [WEIGHT_W-1:0] weight,
    input  logic signed [BIAS_W-1:0]   bias,
    output logic signed [OUT_W-1:0]    result,
    output logic                       result_valid,
    output logic                       sat,
    output logic        [CNT_W-1:0]    mac_count
);

    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = -OUT_MAX - 1;

    // Bias add at one bit of headroom, arithmetic shift, optional ReLU clamp.
    function automatic logic signed [ACC_W:0] scale(input logic signed [ACC_W-1:0] a,
                                                    input logic signed [BIAS_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-BIAS_W){b[BIAS_W-1]}}, b};
        s = s >>> SHIFT;
        if (RELU != 0 && s < 0) s = '0;
        return s;
    endfunction

    // Returns {sat, value}; sat only reflects this clamp, never the ReLU.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] s);
        logic [OUT_W:0] r;
        if (s > OUT_MAX)      r = {1'b1, OUT_MAX[OUT_W-1:0]};
        else if (s < OUT_MIN) r = {1'b1, OUT_MIN[OUT_W-1:0]};
        else                  r = {1'b0, s[OUT_W-1:0]};
        return r;
    endfunction

    // Stage D: strobes delayed to match pixel/weight arrival
    strobe_t strb_p0, strb_d;
    assign strb_p0 = {clr_acc, valid_mac, done};

    strobe_delay #(.DEPTH(MEM_LAT), .WIDTH($bits(strobe_t))) u_strobe_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (strb_p0),
        .dout (strb_d)
    );

    // Stage M: product of zero-extended pixel and signed weight
    logic signed [PROD_W-1:0] px_ext, wt_ext, prod_p1;
    logic                     vld_p1, clr_p1, done_p1;

    assign px_ext = {{(PROD_W-PIXEL_W){1'b0}}, pixel};
    assign wt_ext = {{(PROD_W-WEIGHT_W){weight[WEIGHT_W-1]}}, weight};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            clr_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= strb_d.vld;
            clr_p1  <= strb_d.clr;
            done_p1 <= strb_d.done;
        end
    end

    always_ff @(posedge clk) begin
        if (strb_d.vld) prod_p1 <= px_ext * wt_ext;
    end

    // Stage A: accumulate; the finalize path taps acc_next so a same-cycle term counts
    logic signed [ACC_W-1:0] acc_p2, acc_next;
    logic        [CNT_W-1:0] cnt_p2, cnt_next;
    logic        [OUT_W:0]   fin;

    always_comb begin
        acc_next = clr_p1 ? '0 : acc_p2;
        cnt_next = clr_p1 ? '0 : cnt_p2;
        if (vld_p1) begin
            acc_next = acc_next + {{(ACC_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};
            cnt_next = cnt_next + CNT_W'(1);
        end
    end

    assign fin = saturate(scale(acc_next, bias));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2       <= '0;
            cnt_p2       <= '0;
            result       <= '0;
            sat          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            acc_p2       <= acc_next;
            cnt_p2       <= cnt_next;
            result_valid <= done_p1;
            if (done_p1) begin
                sat    <= fin[OUT_W];
                result <= fin[OUT_W-1:0];
            end
        end
    end

    assign mac_count = cnt_p2;

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: three instances (SHIFT/RELU variants) share one stimulus stream.
module tb_mac_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic               clr_acc, valid_mac, done;
    logic        [7:0]  pixel;
    logic signed [7:0]  weight;
    logic signed [15:0] bias;

    logic signed [15:0] res0, res1, res2;
    logic               rv0, rv1, rv2, sat0, sat1, sat2;
    logic        [9:0]  cnt0, cnt1, cnt2;

    mac_unit #(.MEM_LAT(1), .ACC_W(32), .OUT_W(16), .SHIFT(0), .RELU(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr_acc(clr_acc), .valid_mac(valid_mac), .done(done),
        .pixel(pixel), .weight(weight), .bias(bias),
        .result(res0), .result_valid(rv0), .sat(sat0), .mac_count(cnt0));
    mac_unit #(.MEM_LAT(1), .ACC_W(32), .OUT_W(16), .SHIFT(8), .RELU(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr_acc(clr_acc), .valid_mac(valid_mac), .done(done),
        .pixel(pixel), .weight(weight), .bias(bias),
        .result(res1), .result_valid(rv1), .sat(sat1), .mac_count(cnt1));
    mac_unit #(.MEM_LAT(1), .ACC_W(32), .OUT_W(16), .SHIFT(8), .RELU(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clr_acc(clr_acc), .valid_mac(valid_mac), .done(done),
        .pixel(pixel), .weight(weight), .bias(bias),
        .result(res2), .result_valid(rv2), .sat(sat2), .mac_count(cnt2));

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: running dot product since the last clear, snapshotted at done.
    longint             m_sum;
    int                 m_cnt;
    longint             d_sum;
    int                 d_cnt;
    logic        [7:0]  nxt_px;
    logic signed [7:0]  nxt_wt;

    logic               s_rv  [3];
    logic signed [15:0] s_res [3];
    logic               s_sat [3];
    logic        [9:0]  s_cnt [3];

    function automatic int shift_of(int i);
        return (i == 0) ? 0 : 8;
    endfunction

    function automatic bit relu_of(int i);
        return (i != 1);
    endfunction

    function automatic longint fval(longint sum, int b, int i);
        longint f;
        f = (longint'(int'(sum)) + longint'(b)) >>> shift_of(i);
        if (relu_of(i) && f < 0) f = 0;
        return f;
    endfunction

    function automatic logic signed [15:0] exp_res(longint sum, int b, int i);
        longint f;
        f = fval(sum, b, i);
        if (f > 32767)  return 16'sh7fff;
        if (f < -32768) return 16'sh8000;
        return 16'(f);
    endfunction

    function automatic logic exp_sat(longint sum, int b, int i);
        longint f;
        f = fval(sum, b, i);
        return (f > 32767) || (f < -32768);
    endfunction

    // One controller cycle: sample outputs, then drive strobes for this address and
    // the memory data belonging to the previous one; px/wt return next cycle.
    task automatic step(input logic c, input logic v, input logic d,
                        input logic [7:0] px, input logic signed [7:0] wt);
        @(negedge clk);
        s_rv[0] = rv0;  s_res[0] = res0;  s_sat[0] = sat0;  s_cnt[0] = cnt0;
        s_rv[1] = rv1;  s_res[1] = res1;  s_sat[1] = sat1;  s_cnt[1] = cnt1;
        s_rv[2] = rv2;  s_res[2] = res2;  s_sat[2] = sat2;  s_cnt[2] = cnt2;
        clr_acc   = c;
        valid_mac = v;
        done      = d;
        pixel     = nxt_px;
        weight    = nxt_wt;
        nxt_px    = px;
        nxt_wt    = wt;
        if (c) begin
            m_sum = 0;
            m_cnt = 0;
        end
        if (v) begin
            m_sum += longint'(int'(px) * int'(wt));
            m_cnt++;
        end
        if (d) begin
            d_sum = m_sum;
            d_cnt = m_cnt;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    // Run idle cycles after a done and check the single pulse at done+3 plus the result.
    task automatic finish_neuron(input string tag);
        for (int k = 1; k <= 6; k++) begin
            idle();
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (s_rv[i] !== (k == 3)) begin
                    n_fail++;
                    $display("FAIL %s rv[%0d] cyc+%0d: got %b want %b", tag, i, k, s_rv[i], (k == 3));
                end
                if (k == 3) begin
                    n_chk++;
                    if (s_res[i] !== exp_res(d_sum, int'(bias), i)) begin
                        n_fail++;
                        $display("FAIL %s result[%0d]: got %0d want %0d", tag, i, s_res[i],
                                 exp_res(d_sum, int'(bias), i));
                    end
                    n_chk++;
                    if (s_sat[i] !== exp_sat(d_sum, int'(bias), i)) begin
                        n_fail++;
                        $display("FAIL %s sat[%0d]: got %b want %b", tag, i, s_sat[i],
                                 exp_sat(d_sum, int'(bias), i));
                    end
                    n_chk++;
                    if (s_cnt[i] !== 10'(d_cnt)) begin
                        n_fail++;
                        $display("FAIL %s mac_count[%0d]: got %0d want %0d", tag, i, s_cnt[i], d_cnt);
                    end
                end
            end
        end
    endtask

    task automatic run_neuron(input int n, input logic [7:0] px, input logic signed [7:0] wt,
                              input string tag);
        step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, px, wt);
        step(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
        finish_neuron(tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr_acc = 1'b0; valid_mac = 1'b0; done = 1'b0;
        pixel = '0; weight = '0; bias = '0;
        nxt_px = '0; nxt_wt = '0;
        m_sum = 0; m_cnt = 0; d_sum = 0; d_cnt = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({res0, res1, res2, rv0, rv1, rv2, sat0, sat1, sat2, cnt0, cnt1, cnt2} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got res=%0d/%0d/%0d rv=%b%b%b sat=%b%b%b cnt=%0d want all 0",
                     res0, res1, res2, rv0, rv1, rv2, sat0, sat1, sat2, cnt0);
        end
    endtask

    task automatic test_ones_sweep();
        bias = 16'sd0;
        run_neuron(784, 8'd1, 8'sd1, "ones_sweep");
    endtask

    task automatic test_neg_saturation();
        bias = 16'sd0;
        run_neuron(784, 8'd255, -8'sd128, "neg_sat");
        n_chk++;
        if (d_sum !== -64'sd25589760) begin
            n_fail++;
            $display("FAIL neg_sat model_sum: got %0d want -25589760", d_sum);
        end
    endtask

    task automatic test_bias_relu();
        bias = 16'sd100;
        run_neuron(10, 8'd2, -8'sd3, "bias100");
        bias = 16'sd50;
        run_neuron(10, 8'd2, -8'sd3, "bias50_relu");
    endtask

    task automatic test_gapped_clear();
        bias = 16'sd0;
        for (int k = 0; k < 20; k++) step(1'b0, 1'($urandom), 1'b0, 8'($urandom), 8'($urandom));
        step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        step(1'b0, 1'b1, 1'b0, 8'd3, 8'sd5);
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'd200, 8'sd100);
        step(1'b0, 1'b1, 1'b0, 8'd3, 8'sd5);
        step(1'b0, 1'b0, 1'b1, 8'd200, 8'sd100);
        finish_neuron("gapped");
    endtask

    task automatic test_back_to_back();
        longint             sum1;
        logic signed [15:0] want1;
        bias = 16'sd7;
        step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
        step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
        sum1  = d_sum;
        want1 = exp_res(sum1, 7, 0);
        step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        step(1'b0, 1'b1, 1'b0, 8'd9, -8'sd9);
        step(1'b0, 1'b1, 1'b0, 8'd9, -8'sd9);
        n_chk++;
        if (s_rv[0] !== 1'b1 || s_res[0] !== want1) begin
            n_fail++;
            $display("FAIL b2b_first: got rv=%b res=%0d want rv=1 res=%0d", s_rv[0], s_res[0], want1);
        end
        step(1'b0, 1'b1, 1'b0, 8'd9, -8'sd9);
        step(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
        finish_neuron("b2b_second");
    endtask

    task automatic test_random();
        for (int n = 0; n < 5; n++) begin
            int len;
            bit keep;
            len  = $urandom_range(1, 40);
            keep = (n == 3);
            bias = 16'($urandom);
            if (!keep) step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
            for (int k = 0; k < len; k++) begin
                step(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
                if ($urandom_range(0, 3) == 0) idle();
            end
            if ($urandom_range(0, 1) == 1)
                step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom));
            else
                step(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom));
            finish_neuron(keep ? "rand_noclr" : "rand");
        end
    endtask

    task automatic test_reset_midstream();
        bias = 16'sd0;
        step(1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 400; k++) step(1'b0, 1'b1, 1'b0, 8'd1, 8'sd1);
        rst_n = 1'b0;
        valid_mac = 1'b0; clr_acc = 1'b0; done = 1'b0;
        m_sum = 0; m_cnt = 0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (res0 !== 16'sd0 || rv0 !== 1'b0 || cnt0 !== 10'd0 || cnt1 !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got res=%0d rv=%b cnt=%0d/%0d want 0 0 0/0",
                     res0, rv0, cnt0, cnt1);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idle();
            n_chk++;
            if (s_rv[0] !== 1'b0 || s_rv[1] !== 1'b0 || s_rv[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_no_pulse: got rv=%b%b%b want 000", s_rv[0], s_rv[1], s_rv[2]);
            end
        end
        run_neuron(784, 8'd1, 8'sd1, "after_reset_sweep");
    endtask

    initial begin
        test_reset();
        test_ones_sweep();
        test_neg_saturation();
        test_bias_relu();
        test_gapped_clear();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_unit.md
Name: mac_unit

Overview:
- Neuron datapath stage directly downstream of the per-neuron address/sequence controller.
- Consumes the controller's clr_acc / valid_mac / done strobes plus the pixel and weight words returned by the image and weight memories for the issued address.
- Aligns the strobes to memory read latency, multiplies, accumulates 784 products, then adds bias, scales, applies optional ReLU and saturates.
- Presents one neuron activation with a single-cycle result_valid pulse to the argmax/output layer.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from address to data (must be >=1).
- ACC_W, 32, signed accumulator width.
- OUT_W, 16, signed result width.
- SHIFT, 0, arithmetic right shift applied after bias add.
- RELU, 1, 1 = clamp negative results to 0; 0 = signed output.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_acc  in  1  controller strobe, one cycle before the first valid_mac; clears the accumulator.
- valid_mac  in  1  controller strobe; the address issued this cycle is a valid term.
- done  in  1  controller end-of-neuron strobe, one cycle after the last valid_mac.
- pixel  in  8  unsigned pixel from image memory, valid MEM_LAT cycles after its address.
- weight  in  8  signed weight from weight memory, same alignment as pixel.
- bias  in  16  signed neuron bias; sampled in the finalize cycle.
- result  out  OUT_W  signed activation; holds until the next finalize.
- result_valid  out  1  one-cycle pulse when result updates.
- sat  out  1  high with result_valid if saturation occurred; holds with result.
- mac_count  out  10  number of products accumulated since the last clear; diagnostic.

Behaviour:
- Reset: async assertion clears all pipeline flags, the accumulator, result, result_valid, sat and mac_count to 0. Reset mid-operation abandons the neuron, and no result_valid is produced for it.
- Stage D (alignment):
  - clr_acc, valid_mac and done each pass through a MEM_LAT-deep register delay.
  - Delayed strobes (clr_d, valid_d, done_d) are cycle-aligned with pixel/weight.
- Stage M (multiply):
  - On valid_d, register prod = {1'b0,pixel} * weight as a 17-bit signed value; prod_v <= 1.
  - Otherwise prod_v <= 0 and prod holds.
  - clr_d and done_d are registered alongside as clr_m and done_m.
  - Pixel/weight are ignored whenever valid_d is 0.
- Stage A (accumulate):
  - acc_next = (clr_m ? 0 : acc) + (prod_v ? sext(prod) : 0).
  - The accumulator is updated with acc_next every cycle.
  - mac_count follows the same rule: clr_m resets it to 0, prod_v adds 1.
  - clr_m together with prod_v yields acc = prod, mac_count = 1.
  - The accumulator wraps modulo 2^ACC_W; this is not reachable with 784 terms at default widths.
- Finalize (cycle with done_m = 1):
  - f = (acc_next + sext(bias)) >>> SHIFT.
  - If RELU and f < 0, f = 0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat = 1 if the saturation clamp changed the value; the ReLU clamp does not set sat.
  - Register result and sat; result_valid <= 1 for exactly one cycle.
- Latency: controller done at cycle D -> result_valid high at cycle D+MEM_LAT+2. A term issued in the same cycle as done is still included.
- Back-to-back neurons: a new clr_acc may arrive as early as the cycle after done, because the strobes are pipelined independently. The accumulator is not cleared by finalize, only by clr.
- done without a preceding clr: finalizes the running accumulator; this is legal.
- Two dones closer than 1 cycle apart cannot occur; the block needs no check for it.

Decomposition:
- Shared package mnist_pkg:
  - PIXEL_W = 8, WEIGHT_W = 8, PROD_W = 17, N_PIXELS = 784.
  - Default ACC_W/OUT_W constants.
- One natural sub-module: strobe_delay, a parameterised DEPTH x WIDTH shift register with async active-low reset to 0.
  - Instantiated once for {clr_acc, valid_mac, done} with DEPTH = MEM_LAT.

Test Plan:
- Ones sweep: clr, 784 valids with pixel=1 weight=1, bias=0, SHIFT=0 -> result=784, sat=0, mac_count=784, result_valid one pulse at done+3 (MEM_LAT=1).
- Negative saturation: 784 x (pixel=255, weight=-128), SHIFT=8, RELU=0 -> acc=-25589760, f=-99960 -> result=-32768, sat=1. Same with RELU=1 -> result=0, sat=0.
- Bias/ReLU: 10 x (pixel=2, weight=-3), bias=100 -> result=40. With bias=50, RELU=1 -> result=0.
- Gapped stream with clear: accumulate garbage, then clr, then two valids (pixel=3, weight=5) separated by 4 idle cycles carrying pixel=200 weight=100 -> result=30, mac_count=2.
- Back-to-back neurons: clr asserted the cycle after done -> first result unaffected, second neuron starts from 0.
- Reset mid-stream: rst_n low for 2 cycles at valid #400 -> result=0, result_valid=0, mac_count=0. A subsequent full ones sweep gives 784.
